// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and types for the PWM ramp scheduler.
//   NUM_CH_DEF / DUTY_W_DEF / DIV_W_DEF : default channel count and widths
//   CH_W                                : channel-index width (cmd_ch)
//   ch_state_e                          : per-channel FSM states
package pwm_pkg;
   localparam int NUM_CH_DEF = 3;
   localparam int DUTY_W_DEF = 8;
   localparam int DIV_W_DEF  = 8;
   localparam int CH_W       = $clog2(NUM_CH_DEF);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RAMP = 1'b1
   } ch_state_e;
endpackage

// File: rtl/pwm_ramp_channel.sv
// pwm_ramp_channel: one channel's ramp FSM, interval counter and stepper.
//   clk, reset_n       : clock, async active-low reset
//   load_i             : accept a new command for this channel
//   target_i/step_i/div_i : command fields
//   period_complete_i  : PWM period boundary pulse
//   duty_o             : current duty value (changes only on period boundaries)
//   busy_o             : ramp in progress
//   done_o             : one-cycle pulse when the target is reached
module pwm_ramp_channel
   import pwm_pkg::*;
#(
   parameter int DUTY_W = DUTY_W_DEF,
   parameter int DIV_W  = DIV_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load_i,
   input  logic [DUTY_W-1:0] target_i,
   input  logic [DUTY_W-1:0] step_i,
   input  logic [DIV_W-1:0]  div_i,
   input  logic              period_complete_i,
   output logic [DUTY_W-1:0] duty_o,
   output logic              busy_o,
   output logic              done_o
);

   ch_state_e         state_q, state_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic [DUTY_W-1:0] tgt_q, tgt_d;
   logic [DUTY_W-1:0] step_q, step_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic              done_q, done_d;

   // Distance to target, one bit wider so the compare against step is exact.
   logic              up;
   logic [DUTY_W:0]   diff;

   always_comb begin
      up   = (tgt_q > duty_q);
      diff = up ? ({1'b0, tgt_q} - {1'b0, duty_q})
                : ({1'b0, duty_q} - {1'b0, tgt_q});
   end

   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      tgt_d   = tgt_q;
      step_d  = step_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;

      // A load takes priority over a coincident period pulse, so that pulse
      // is not counted toward the new ramp. Preemption keeps duty_q as-is.
      if (load_i) begin
         tgt_d  = target_i;
         step_d = step_i;
         div_d  = div_i;
         cnt_d  = div_i;
         if (target_i == duty_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end else begin
            state_d = ST_RAMP;
         end
      end else if (state_q == ST_RAMP && period_complete_i) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
         end else begin
            cnt_d = div_q;
            // Final step lands exactly on target; no overshoot or wrap.
            if (step_q == '0 || diff <= {1'b0, step_q}) begin
               duty_d  = tgt_q;
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else if (up) begin
               duty_d = duty_q + step_q;
            end else begin
               duty_d = duty_q - step_q;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         duty_q  <= '0;
         tgt_q   <= '0;
         step_q  <= '0;
         div_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         duty_q  <= duty_d;
         tgt_q   <= tgt_d;
         step_q  <= step_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign duty_o = duty_q;
   assign busy_o = (state_q == ST_RAMP);
   assign done_o = done_q;

endmodule

// File: rtl/pwm_ramp_scheduler.sv
// pwm_ramp_scheduler: per-channel duty ramp sequencer for the PWM controller.
//   clk, reset_n    : clock, async active-low reset
//   cmd_valid/ready : command handshake (ready high whenever out of reset)
//   cmd_ch          : channel index; out-of-range commands are dropped
//   cmd_target/step/div : ramp target, step size (0 = jump), periods per step - 1
//   period_complete : timer pulse; duty changes only on this pulse
//   duty_out        : packed duty values, channel i at [DUTY_W*i +: DUTY_W]
//   busy / done     : per-channel ramp active / reached-target pulse
//   cmd_err         : pulse for an accepted out-of-range command
module pwm_ramp_scheduler
   import pwm_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int DUTY_W = DUTY_W_DEF,
   parameter int DIV_W  = DIV_W_DEF
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [CH_W-1:0]          cmd_ch,
   input  logic [DUTY_W-1:0]        cmd_target,
   input  logic [DUTY_W-1:0]        cmd_step,
   input  logic [DIV_W-1:0]         cmd_div,
   input  logic                     period_complete,
   output logic [NUM_CH*DUTY_W-1:0] duty_out,
   output logic [NUM_CH-1:0]        busy,
   output logic [NUM_CH-1:0]        done,
   output logic                     cmd_err
);

   localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

   logic                           cmd_ready_q;
   logic                           cmd_err_q, cmd_err_d;
   logic                           accept;
   logic [NUM_CH-1:0]              load;
   logic [NUM_CH-1:0][DUTY_W-1:0]  duty_w;

   assign accept    = cmd_valid & cmd_ready_q;
   assign cmd_err_d = accept && ({1'b0, cmd_ch} >= NUM_CH_L);

   // cmd_ready comes up one edge after reset release and then stays high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_ready_q <= 1'b0;
         cmd_err_q   <= 1'b0;
      end else begin
         cmd_ready_q <= 1'b1;
         cmd_err_q   <= cmd_err_d;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign load[i] = accept && (cmd_ch == CH_W'(i));

      pwm_ramp_channel #(
         .DUTY_W (DUTY_W),
         .DIV_W  (DIV_W)
      ) u_ch (
         .clk               (clk),
         .reset_n           (reset_n),
         .load_i            (load[i]),
         .target_i          (cmd_target),
         .step_i            (cmd_step),
         .div_i             (cmd_div),
         .period_complete_i (period_complete),
         .duty_o            (duty_w[i]),
         .busy_o            (busy[i]),
         .done_o            (done[i])
      );
   end

   assign duty_out  = duty_w;
   assign cmd_ready = cmd_ready_q;
   assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_pwm_ramp_scheduler.sv
// Scoreboard bench: stimulus pushes hand-computed output events; a monitor
// pops one per observed event (duty change, done pulse or cmd_err pulse).
module tb_pwm_ramp_scheduler;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_ch;
   logic [7:0]  cmd_target;
   logic [7:0]  cmd_step;
   logic [7:0]  cmd_div;
   logic        period_complete;
   logic [23:0] duty_out;
   logic [2:0]  busy;
   logic [2:0]  done;
   logic        cmd_err;

   typedef struct {
      logic [23:0] duty;
      logic [2:0]  busy;
      logic [2:0]  done;
      logic        err;
   } ev_t;

   ev_t         exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [23:0] prev_duty = '0;

   pwm_ramp_scheduler dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_ch          (cmd_ch),
      .cmd_target      (cmd_target),
      .cmd_step        (cmd_step),
      .cmd_div         (cmd_div),
      .period_complete (period_complete),
      .duty_out        (duty_out),
      .busy            (busy),
      .done            (done),
      .cmd_err         (cmd_err)
   );

   always #5 clk = ~clk;

   task automatic push(input int d2, input int d1, input int d0,
                       input int b, input int dn, input int e);
      ev_t ev;
      ev.duty = {8'(d2), 8'(d1), 8'(d0)};
      ev.busy = 3'(b);
      ev.done = 3'(dn);
      ev.err  = 1'(e);
      exp_q.push_back(ev);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Tasks start and end at #1 after a rising edge.
   task automatic cmd(input int ch, input int tgt, input int stp, input int dv);
      cmd_valid  = 1'b1;
      cmd_ch     = 2'(ch);
      cmd_target = 8'(tgt);
      cmd_step   = 8'(stp);
      cmd_div    = 8'(dv);
      @(posedge clk); #1;
      cmd_valid  = 1'b0;
   endtask

   task automatic pc(input int n);
      for (int k = 0; k < n; k++) begin
         period_complete = 1'b1;
         @(posedge clk); #1;
         period_complete = 1'b0;
         repeat (15) begin @(posedge clk); #1; end
      end
   endtask

   // Monitor: every observable event must match the next expected one.
   always @(negedge clk) begin
      if (duty_out !== prev_duty || done !== 3'b0 || cmd_err !== 1'b0) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: duty=%h busy=%b done=%b err=%b, none expected",
                     duty_out, busy, done, cmd_err);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (duty_out !== e.duty || busy !== e.busy || done !== e.done || cmd_err !== e.err) begin
               n_fail++;
               $display("FAIL event: got duty=%h busy=%b done=%b err=%b expected duty=%h busy=%b done=%b err=%b",
                        duty_out, busy, done, cmd_err, e.duty, e.busy, e.done, e.err);
            end
         end
      end
      prev_duty = duty_out;
   end

   initial begin
      reset_n = 1'b0; cmd_valid = 1'b0; cmd_ch = '0; cmd_target = '0;
      cmd_step = '0; cmd_div = '0; period_complete = 1'b0;

      // Reset
      repeat (3) @(posedge clk); #1;
      check("rst_duty", 32'(duty_out), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(cmd_err), 0);
      check("rst_ready", 32'(cmd_ready), 0);
      reset_n = 1'b1;
      #1 check("ready_before_edge", 32'(cmd_ready), 0);
      @(posedge clk); #1;
      check("ready_after_edge", 32'(cmd_ready), 1);

      // Up-ramp ch0: 0 -> 100 step 30
      push(0, 0, 30, 3'b001, 0, 0);
      push(0, 0, 60, 3'b001, 0, 0);
      push(0, 0, 90, 3'b001, 0, 0);
      push(0, 0, 100, 3'b000, 3'b001, 0);
      cmd(0, 100, 30, 0);
      check("up_busy_rise", 32'(busy), 3'b001);
      pc(4);
      check("up_busy_fall", 32'(busy), 0);

      // Down-ramp ch1: jump to 100, then 100 -> 10 step 40 every 3rd period
      push(0, 100, 100, 3'b000, 3'b010, 0);
      cmd(1, 100, 0, 0);
      pc(1);
      push(0, 60, 100, 3'b010, 0, 0);
      push(0, 20, 100, 3'b010, 0, 0);
      push(0, 10, 100, 3'b000, 3'b010, 0);
      cmd(1, 10, 40, 2);
      check("down_busy", 32'(busy), 3'b010);
      pc(2);
      check("down_no_step_yet", 32'(duty_out), {8'd0, 8'd100, 8'd100});
      pc(7);

      // Preemption ch2: 0 -> 200 step 10, cut at 50, then -> 0 step 25
      for (int v = 10; v <= 50; v += 10) push(v, 10, 100, 3'b100, 0, 0);
      cmd(2, 200, 10, 0);
      pc(5);
      push(25, 10, 100, 3'b100, 0, 0);
      push(0, 10, 100, 3'b000, 3'b100, 0);
      cmd(2, 0, 25, 0);
      check("preempt_busy", 32'(busy), 3'b100);
      pc(2);

      // Out-of-range channel
      push(0, 10, 100, 0, 0, 1);
      cmd(3, 77, 1, 0);
      pc(1);

      // Target equals current duty: done next cycle, busy never rises
      push(0, 10, 100, 0, 3'b001, 0);
      cmd(0, 100, 5, 0);
      check("equal_busy", 32'(busy), 0);
      pc(1);

      // Step 0 jump with div 1: lands on the 2nd period
      push(0, 255, 100, 0, 3'b010, 0);
      cmd(1, 255, 0, 1);
      pc(1);
      check("jump_wait", 32'(duty_out), {8'd0, 8'd10, 8'd100});
      pc(1);

      // Reset mid-ramp: ch0 100 -> 60, then reset
      push(0, 255, 60, 3'b001, 0, 0);
      cmd(0, 0, 40, 0);
      pc(1);
      check("mid_busy", 32'(busy), 3'b001);
      push(0, 0, 0, 0, 0, 0);
      reset_n = 1'b0;
      #1;
      check("mid_rst_duty", 32'(duty_out), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_ready", 32'(cmd_ready), 0);
      repeat (2) @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      pc(3);

      // Drain scoreboard
      for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
